// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: start pattern, count field, then payload bits
// (payload LSB first), one bit per Clk_EN-qualified clock edge.
// Optional feature: define SER_TX_PARITY_EN to append one even-parity bit
// after the payload.
module ser_frame_tx #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] START_PAT = 4'b1101,
  parameter int               CNT_W     = 4,
  parameter int               DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Clk_EN,
  input  logic              start,
  input  logic [CNT_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              serOut,
  output logic              serOutValid,
  output logic              done
);

  // Bit counter wide enough for the longest field; it never wraps inside a field.
  localparam int M1   = (PAT_W > CNT_W) ? PAT_W : CNT_W;
  localparam int MAXF = (M1 > (2**CNT_W)) ? M1 : (2**CNT_W);
  localparam int BW   = (MAXF > 1) ? $clog2(MAXF) : 1;

`ifdef SER_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_PAT, S_CNT, S_DATA, S_PAR, S_END} state_t;
  localparam state_t S_AFTER = S_PAR;
`else
  typedef enum logic [2:0] {S_IDLE, S_PAT, S_CNT, S_DATA, S_END} state_t;
  localparam state_t S_AFTER = S_END;
`endif

  state_t            state_q, state_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  lenSh_q, lenSh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              serOut_q, serOut_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
`ifdef SER_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign ready       = (state_q == S_IDLE);
  assign serOut      = serOut_q;
  assign serOutValid = valid_q;
  assign done        = done_q;

  // State and datapath registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      lenSh_q  <= '0;
      data_q   <= '0;
      serOut_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef SER_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      lenSh_q  <= lenSh_d;
      data_q   <= data_d;
      serOut_q <= serOut_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef SER_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic: capture on start in idle, otherwise one bit per enabled edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    len_d    = len_q;
    lenSh_d  = lenSh_q;
    data_d   = data_q;
    serOut_d = serOut_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
`ifdef SER_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_in;
          lenSh_d = len_in;
          data_d  = data_in;
          pat_d   = START_PAT;
          cnt_d   = '0;
`ifdef SER_TX_PARITY_EN
          parity_d = 1'b0;
`endif
          state_d = S_PAT;
        end
      end
      S_PAT: begin
        if (Clk_EN) begin
          serOut_d = pat_q[PAT_W-1];
          valid_d  = 1'b1;
          pat_d    = pat_q << 1;
          if (cnt_q == BW'(PAT_W - 1)) begin
            cnt_d   = '0;
            state_d = S_CNT;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      S_CNT: begin
        if (Clk_EN) begin
          serOut_d = lenSh_q[CNT_W-1];
          valid_d  = 1'b1;
          lenSh_d  = lenSh_q << 1;
          if (cnt_q == BW'(CNT_W - 1)) begin
            cnt_d   = '0;
            state_d = (len_q != '0) ? S_DATA : S_AFTER;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      S_DATA: begin
        if (Clk_EN) begin
          serOut_d = data_q[0];
          valid_d  = 1'b1;
          data_d   = data_q >> 1;
`ifdef SER_TX_PARITY_EN
          parity_d = parity_q ^ data_q[0];
`endif
          if (cnt_q == BW'(len_q) - BW'(1)) begin
            cnt_d   = '0;
            state_d = S_AFTER;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      S_PAR: begin
        if (Clk_EN) begin
          serOut_d = parity_q;
          valid_d  = 1'b1;
          state_d  = S_END;
        end
      end
`endif
      S_END: begin
        if (Clk_EN) begin
          serOut_d = 1'b0;
          valid_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
